// File: rtl/debug_trace_buffer_if.sv
// Bus bundle for the debug trace buffer: writeback feed, trigger setup,
// readback port and status outputs.
interface debug_trace_buffer_if #(
    parameter int ADDR_W = 4
);
    logic [31:0]       wb_instruction;
    logic              wb_valid;
    logic              arm;
    logic [31:0]       trigger_match;
    logic [31:0]       trigger_mask;
    logic [ADDR_W-1:0] rd_index;
    logic [31:0]       rd_data;
    logic [ADDR_W:0]   count;
    logic [1:0]        state;
    logic              triggered;
    logic              done;

    modport master (
        output wb_instruction, wb_valid, arm, trigger_match, trigger_mask, rd_index,
        input  rd_data, count, state, triggered, done
    );

    modport slave (
        input  wb_instruction, wb_valid, arm, trigger_match, trigger_mask, rd_index,
        output rd_data, count, state, triggered, done
    );
endinterface

// File: rtl/debug_trace_buffer.sv
// Circular trace buffer of retired writeback instructions. It stops after a masked
// trigger match plus POST_TRIG further retirements, and is read back oldest-first.
module debug_trace_buffer #(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int POST_TRIG = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    debug_trace_buffer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        POST   = 2'd2,
        FROZEN = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   FULL      = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] POST_INIT = ADDR_W'(POST_TRIG);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] post_cnt, post_d;
    logic [ADDR_W:0]   count_q;
    logic [31:0]       rd_data_q;
    logic [31:0]       mem [DEPTH];
    logic              hit;
    logic              capture;
    logic [ADDR_W-1:0] oldest;
    logic [ADDR_W-1:0] rd_addr;

    assign hit     = bus.wb_valid &&
                     (((bus.wb_instruction ^ bus.trigger_match) & bus.trigger_mask) == 32'd0);
    // arm takes priority over a same-cycle retirement, so that word is dropped
    assign capture = bus.wb_valid && !bus.arm && (state_q == ARMED || state_q == POST);
    assign oldest  = (count_q < FULL) ? '0 : wr_ptr;
    assign rd_addr = oldest + bus.rd_index;

    always_comb begin
        state_d = state_q;
        post_d  = post_cnt;
        if (bus.arm) begin
            state_d = ARMED;
            post_d  = '0;
        end else begin
            case (state_q)
                ARMED: begin
                    if (capture && hit) begin
                        if (POST_TRIG == 0) begin
                            state_d = FROZEN;
                        end else begin
                            state_d = POST;
                            post_d  = POST_INIT;
                        end
                    end
                end
                POST: begin
                    if (capture) begin
                        post_d = post_cnt - ADDR_W'(1);
                        if (post_cnt == ADDR_W'(1)) begin
                            state_d = FROZEN;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_ptr    <= '0;
            count_q   <= '0;
            post_cnt  <= '0;
            rd_data_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            post_cnt <= post_d;
            if (bus.arm) begin
                wr_ptr  <= '0;
                count_q <= '0;
            end else if (capture) begin
                wr_ptr  <= wr_ptr + ADDR_W'(1);
                count_q <= (count_q == FULL) ? count_q : count_q + (ADDR_W+1)'(1);
            end
            // Read uses pre-edge pointer/count, so a same-slot write returns the old word
            rd_data_q <= ({1'b0, bus.rd_index} < count_q) ? mem[rd_addr] : 32'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && capture) begin
            mem[wr_ptr] <= bus.wb_instruction;
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.count     = count_q;
    assign bus.state     = state_q;
    assign bus.triggered = (state_q == POST) || (state_q == FROZEN);
    assign bus.done      = (state_q == FROZEN);
endmodule
